dct_row_serializer: RTL

//  Accepts one transform row of up to 32 signed 16-bit coefficients in parallel.

---
 rtl/dct_row_serializer.sv | 58 +++++
 1 files changed

// File: rtl/dct_row_serializer.sv
// dct_row_serializer: buffers one parallel DCT row and streams its first N coefficients out via valid/ready.
// Ports: clk/rst_n (sync, active-low); i_size,i_val,i_row -> row accept, o_rdy back-pressure;
//        o_val,o_dt,o_idx,o_last -> serial coefficient stream, i_rdy downstream ready.
module dct_row_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [1:0]                              i_size,
  input  logic                                    i_val,
  output logic                                    o_rdy,
  input  logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]   i_row,
  output logic                                    o_val,
  input  logic                                    i_rdy,
  output logic [DATA_WIDTH-1:0]                   o_dt,
  output logic [ADDR_WIDTH-1:0]                   o_idx,
  output logic                                    o_last
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH*DEPTH-1:0] row_q;
  logic [ADDR_WIDTH-1:0] cnt, last_idx;
  logic [1:0] size_q;
  logic send, accept;
  assign last_idx = ADDR_WIDTH'((4 << size_q) - 1);
  assign send     = state == SEND;
  assign o_val    = send;
  assign o_last   = send && cnt == last_idx;
  // New row may only enter while idle or on the final beat of the current row.
  assign o_rdy    = !send || (o_last && i_rdy);
  assign accept   = i_val && o_rdy;
  assign o_idx    = send ? cnt : '0;
  assign o_dt     = send ? row_q[cnt*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    state_nxt = state;
    state_nxt = !send ? (i_val ? SEND : IDLE) : ((o_last && i_rdy && !i_val) ? IDLE : SEND);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      size_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      size_q <= i_size;
    end else if (send && i_rdy && !o_last) begin
      cnt    <= cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) row_q <= i_row;
  end
endmodule
